// File: rtl/jk_reg_bank_pkg.sv
// Shared mode encoding and JK next-state helper for the jk_reg_bank family.
package jk_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t JK_MODE_JK   = 2'b00;
  localparam jk_mode_t JK_MODE_D    = 2'b01;
  localparam jk_mode_t JK_MODE_T    = 2'b10;
  localparam jk_mode_t JK_MODE_HOLD = 2'b11;

  // Classic JK characteristic: hold, reset, set, toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_reg_bank_cell.sv
// Purely combinational next-state function of one JK cell (no storage here).
module jk_cell
  import jk_pkg::*;
(
  input  logic     i_q,
  input  logic     i_j,
  input  logic     i_k,
  input  jk_mode_t i_mode,
  input  logic     i_en,
  output logic     o_q_next
);

  always_comb begin
    o_q_next = i_q;
    if (i_en) begin
      case (i_mode)
        JK_MODE_JK: o_q_next = jk_next(i_q, i_j, i_k);
        JK_MODE_D:  o_q_next = i_j;
        JK_MODE_T:  o_q_next = i_q ^ i_j;
        default:    o_q_next = i_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with enable, JK/D/T/hold mode, parallel load and
// synchronous active-low clear. JK_TOGGLE_CNT_EN adds chg / tgl_cnt outputs.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
`ifdef JK_TOGGLE_CNT_EN
  ,
  parameter int               CNT_W     = 8
`endif
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  jk_mode_t         mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
`ifdef JK_TOGGLE_CNT_EN
  ,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] tgl_cnt
`endif
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_cell_next;
  logic [WIDTH-1:0] w_q_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .i_q      (r_q[gi]),
      .i_j      (j[gi]),
      .i_k      (k[gi]),
      .i_mode   (mode),
      .i_en     (en),
      .o_q_next (w_cell_next[gi])
    );
  end

  // Load beats the cell update; clear beats both and is handled in the flop.
  assign w_q_next = load ? load_val : w_cell_next;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

`ifdef JK_TOGGLE_CNT_EN
  logic [WIDTH-1:0] r_chg;
  logic [CNT_W-1:0] r_tgl_cnt;
  logic [WIDTH-1:0] w_diff;

  assign w_diff = r_q ^ w_q_next;

  // Reset edges neither pulse chg nor count, even if q moves to RESET_VAL.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_chg     <= '0;
      r_tgl_cnt <= '0;
    end else begin
      r_chg <= w_diff;
      if ((|w_diff) && (r_tgl_cnt != {CNT_W{1'b1}})) begin
        r_tgl_cnt <= r_tgl_cnt + 1'b1;
      end
    end
  end

  assign chg     = r_chg;
  assign tgl_cnt = r_tgl_cnt;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=8, RESET_VAL=8'hA5); covers the
// chg / tgl_cnt outputs when built with JK_TOGGLE_CNT_EN.
module tb_jk_reg_bank;
  import jk_pkg::*;

  localparam int         W     = 8;
  localparam logic [7:0] RST_V = 8'hA5;
`ifdef JK_TOGGLE_CNT_EN
  localparam int         CW    = 2;
`endif

  logic         clk;
  logic         clear_n;
  logic         en;
  jk_mode_t     mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
`ifdef JK_TOGGLE_CNT_EN
  logic [W-1:0]  chg;
  logic [CW-1:0] tgl_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  jk_reg_bank #(
    .WIDTH     (W),
    .RESET_VAL (RST_V)
`ifdef JK_TOGGLE_CNT_EN
    ,
    .CNT_W     (CW)
`endif
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .j        (j),
    .k        (k),
    .q        (q),
    .qbar     (qbar)
`ifdef JK_TOGGLE_CNT_EN
    ,
    .chg      (chg),
    .tgl_cnt  (tgl_cnt)
`endif
  );

  // driver: apply one cycle of inputs, clock it, sample #1 after the edge
  task automatic step(input logic c_n, input logic ld, input logic [W-1:0] lv,
                      input logic e, input jk_mode_t m,
                      input logic [W-1:0] jv, input logic [W-1:0] kv);
    @(negedge clk);
    clear_n  = c_n;
    load     = ld;
    load_val = lv;
    en       = e;
    mode     = m;
    j        = jv;
    k        = kv;
    @(posedge clk);
    #1;
  endtask

  // scoreboard check on q and qbar
  task automatic check_q(input string tag, input logic [W-1:0] exp_q);
    tests_run++;
    assert (q === exp_q) else begin
      tests_failed++;
      $error("FAIL %s q: got %h expected %h", tag, q, exp_q);
    end
    tests_run++;
    assert (qbar === ~exp_q) else begin
      tests_failed++;
      $error("FAIL %s qbar: got %h expected %h", tag, qbar, ~exp_q);
    end
  endtask

`ifdef JK_TOGGLE_CNT_EN
  task automatic check_cnt(input string tag, input logic [W-1:0] exp_chg,
                           input logic [CW-1:0] exp_cnt);
    tests_run++;
    assert (chg === exp_chg) else begin
      tests_failed++;
      $error("FAIL %s chg: got %h expected %h", tag, chg, exp_chg);
    end
    tests_run++;
    assert (tgl_cnt === exp_cnt) else begin
      tests_failed++;
      $error("FAIL %s tgl_cnt: got %0d expected %0d", tag, tgl_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    clear_n  = 1'b1;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    mode     = JK_MODE_HOLD;
    j        = '0;
    k        = '0;

    // reset overrides load and en
    step(1'b0, 1'b1, 8'hFF, 1'b1, JK_MODE_JK, 8'hFF, 8'hFF);
    check_q("reset", 8'hA5);
`ifdef JK_TOGGLE_CNT_EN
    check_cnt("reset_cnt", 8'h00, 2'd0);
`endif

    // JK truth table from 0F
    step(1'b1, 1'b1, 8'h0F, 1'b0, JK_MODE_HOLD, 8'h00, 8'h00);
    check_q("load_0f", 8'h0F);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_JK, 8'hF0, 8'h0C);
    check_q("jk_set_reset_hold", 8'hF3);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_JK, 8'hFF, 8'hFF);
    check_q("jk_toggle", 8'h0C);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_JK, 8'h00, 8'h00);
    check_q("jk_hold", 8'h0C);
    step(1'b1, 1'b0, 8'h00, 1'b0, JK_MODE_JK, 8'hFF, 8'hFF);
    check_q("jk_en0", 8'h0C);

    // D / T / hold modes from 00
    step(1'b1, 1'b1, 8'h00, 1'b0, JK_MODE_HOLD, 8'h00, 8'h00);
    check_q("load_00", 8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_D, 8'h3C, 8'hFF);
    check_q("d_mode", 8'h3C);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'h0F, 8'h00);
    check_q("t_mode_1", 8'h33);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'h0F, 8'h00);
    check_q("t_mode_2", 8'h3C);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_HOLD, 8'hFF, 8'hFF);
    check_q("hold_mode", 8'h3C);

    // priority: load beats the toggle; en=0 beats D
    step(1'b1, 1'b1, 8'h81, 1'b1, JK_MODE_JK, 8'hFF, 8'hFF);
    check_q("load_priority", 8'h81);
    step(1'b1, 1'b0, 8'h00, 1'b0, JK_MODE_D, 8'hFF, 8'h00);
    check_q("en0_d_hold", 8'h81);

    // reset mid-stream while toggling in T mode
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'hFF, 8'h00);
    check_q("stream_t1", 8'h7E);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'hFF, 8'h00);
    check_q("stream_t2", 8'h81);
    step(1'b0, 1'b1, 8'h11, 1'b1, JK_MODE_T, 8'hFF, 8'h00);
    check_q("stream_reset", 8'hA5);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'hFF, 8'h00);
    check_q("stream_resume", 8'h5A);

`ifdef JK_TOGGLE_CNT_EN
    // fresh reset, then four changing edges and one quiet edge
    step(1'b0, 1'b0, 8'h00, 1'b0, JK_MODE_HOLD, 8'h00, 8'h00);
    check_q("cnt_reset", 8'hA5);
    check_cnt("cnt_reset", 8'h00, 2'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'h01, 8'h00);
    check_q("cnt_1", 8'hA4);
    check_cnt("cnt_1", 8'h01, 2'd1);
    step(1'b1, 1'b1, 8'hA7, 1'b0, JK_MODE_HOLD, 8'h00, 8'h00);
    check_q("cnt_2_load", 8'hA7);
    check_cnt("cnt_2_load", 8'h03, 2'd2);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'h80, 8'h00);
    check_q("cnt_3", 8'h27);
    check_cnt("cnt_3", 8'h80, 2'd3);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_T, 8'h80, 8'h00);
    check_q("cnt_sat", 8'hA7);
    check_cnt("cnt_sat", 8'h80, 2'd3);
    step(1'b1, 1'b0, 8'h00, 1'b1, JK_MODE_D, 8'hA7, 8'h00);
    check_q("cnt_quiet", 8'hA7);
    check_cnt("cnt_quiet", 8'h00, 2'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised successor to the single master-slave JK flip-flop: a WIDTH-bit bank of edge-triggered JK cells with per-bit J/K inputs.
- Adds a global enable, a runtime mode select (JK / D / T / hold), synchronous parallel load and a parametrised reset value.
- Used as the generic state-register primitive for counters, flag banks and toggle registers in the sequential-examples set.
- Single-clock, fully synchronous; q/qbar are registered outputs.

Parameters:
- WIDTH, 8, number of JK cells in the bank (1..64).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 8, width of the per-bank toggle counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- clear_n  input  1  reset: synchronous, active-low.
- en  input  1  global update enable; 0 = all cells hold.
- mode  input  2  00 JK, 01 D (j = d, k ignored), 10 T (j = t, k ignored), 11 hold.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to q when load=1.
- j  input  WIDTH  per-bit J / D / T input, depending on mode.
- k  input  WIDTH  per-bit K input (JK mode only).
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always ~q, derived combinationally from the q register; never independently registered.

Behaviour:
- Reset: clear_n=0 sampled at a rising edge sets q=RESET_VAL, qbar=~RESET_VAL. It overrides load, en and mode.
- Reset mid-operation: asserting clear_n=0 in any cycle discards that cycle's load/J/K; q=RESET_VAL is visible after that edge.
- Priority at each rising edge is clear_n=0, then load=1, then en=1 with mode, else hold.
- load=1: q <= load_val regardless of en and mode.
- en=0 and load=0: q holds.
- Update latency: one edge. Inputs are sampled at edge N; the new q is visible after edge N. No combinational path from inputs to q/qbar.
- JK mode, per bit i:
  - j=0, k=0: hold.
  - j=0, k=1: q[i]<=0.
  - j=1, k=0: q[i]<=1.
  - j=1, k=1: q[i]<=~q[i].
- D mode: q[i]<=j[i].
- T mode: q[i]<=q[i]^j[i].
- mode=11: hold, identical to en=0.
- Bits are independent. No carry or interaction between cells.
- X-safety: mode values outside the defined set cannot occur (2-bit, all decoded). The default case is hold.
- No clock gating; en is a data-path mux.

Optional Feature:
- Macro: JK_TOGGLE_CNT_EN.
- When defined, adds two outputs:
  - chg  output  WIDTH: registered one-cycle pulse, chg[i]=1 in the cycle after q[i] changed value (including changes caused by load). Reset value 0.
  - tgl_cnt  output  CNT_W: saturating count of edges on which at least one bit of q changed, excluding reset edges. Resets to 0 and sticks at all-ones.
- When not defined: neither port exists, no extra flops are instantiated, and the remaining behaviour is identical.

Decomposition:
- Package jk_pkg holds:
  - mode constants JK_MODE_JK=2'b00, JK_MODE_D=2'b01, JK_MODE_T=2'b10, JK_MODE_HOLD=2'b11;
  - a typedef jk_mode_t for the 2-bit mode field.
- One sub-module, jk_cell: a purely combinational next-state function of (q, j, k, mode, en).
  - The bank instantiates it WIDTH times via generate and holds the q register plus the load/reset muxing itself.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5; drive clear_n=0 with load=1, load_val=8'hFF, en=1 -> after the edge q=8'hA5, qbar=8'h5A.
- JK truth table, mode=00, en=1, starting from q=8'h0F: j=8'hF0, k=8'h0C -> q=8'hF3. Next cycle j=k=8'hFF -> q=8'h0C. Next cycle j=k=0 -> q stays 8'h0C.
- D/T modes from q=8'h00:
  - mode=01, j=8'h3C -> q=8'h3C;
  - mode=10, j=8'h0F -> q=8'h33;
  - mode=10 again -> q=8'h3C;
  - mode=11, j=8'hFF -> q unchanged 8'h3C.
- Priority: load=1, load_val=8'h81, en=1, mode=00, j=k=8'hFF -> q=8'h81 (the toggle is ignored). en=0 with j=8'hFF in D mode -> q holds 8'h81.
- Reset mid-stream: toggle q every cycle in T mode, drop clear_n for one cycle -> q=RESET_VAL on that edge. Toggling resumes from RESET_VAL the next edge.
- JK_TOGGLE_CNT_EN build, CNT_W=2: four consecutive cycles with a bit change, one cycle without -> tgl_cnt reads 1,2,3,3 and holds at 3. chg pulses one cycle after each changed bit only.
